// File: rtl/sub_serial.sv
// sub_serial: bit-serial unsigned subtractor, one bit per clock, LSB first.
// d = a - b - bin mod 2^(WIDTH+1); d[WIDTH] is the final borrow-out.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   async active-low reset
//   start  in   begin an operation (ignored while busy)
//   a, b   in   WIDTH-bit unsigned minuend / subtrahend
//   bin    in   borrow-in
//   busy   out  high while bits are being shifted
//   done   out  one-cycle pulse with a fresh d
//   d      out  {borrow, difference}, held between results
module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]   cnt;
  logic            br;

  logic            dk;
  logic            br_n;

  // a_q doubles as the result shifter: the low operand bit
  // is consumed and the new difference bit enters at the top,
  // so after WIDTH shifts it holds the whole difference.
  assign dk   = a_q[0] ^ b_q[0] ^ br;
  assign br_n = (~a_q[0] & b_q[0])
              | (~(a_q[0] ^ b_q[0]) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br    <= bin;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          a_q <= {dk, a_q[WIDTH-1:1]};
          b_q <= b_q >> 1;
          br  <= br_n;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            d     <= {br_n, dk, a_q[WIDTH-1:1]};
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed checks for sub_serial, WIDTH=4.
// Hand-computed vectors plus an exhaustive operand sweep.
module tb_sub_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [4:0] d;

  int n_chk = 0;
  int n_err = 0;

  sub_serial #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Launch one op, scramble inputs while busy,
  // return d at the done cycle and busy-cycle count.
  task automatic do_op(input logic [3:0] ta,
                       input logic [3:0] tb_,
                       input logic tbin,
                       output logic [4:0] got,
                       output int lat,
                       output logic bsy);
    int n;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb_; bin = ~tbin;
    lat = 0;
    n = 0;
    while (!done && n < 20) begin
      if (busy) lat++;
      n++;
      @(negedge clk);
    end
    if (!done) lat = -1;
    got = d;
    bsy = busy;
  endtask

  task automatic op_check(input string tag,
                          input logic [3:0] ta,
                          input logic [3:0] tb_,
                          input logic tbin,
                          input logic [4:0] exp);
    logic [4:0] got;
    int lat;
    logic bsy;
    do_op(ta, tb_, tbin, got, lat, bsy);
    chk({tag, "_d"}, got, exp);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_busy_at_done"}, bsy, 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_d_hold"}, d, exp);
  endtask

  logic [3:0] sa [4] = '{4'd9, 4'd3, 4'd15, 4'd8};
  logic [3:0] sb [4] = '{4'd4, 4'd5, 4'd15, 4'd7};
  logic       sc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [4:0] se [4] = '{5'h05, 5'h1E, 5'h1F, 5'h00};

  initial begin
    int ndone;
    int nbusy;
    int cyc;
    int last;
    int viol;
    int i;
    logic [4:0] cap;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    op_check("r031", 4'd9, 4'd4, 1'b0, 5'h05);
    op_check("r032a", 4'd3, 4'd5, 1'b0, 5'h1E);
    op_check("r032b", 4'd0, 4'd0, 1'b1, 5'h1F);
    op_check("r032c", 4'd15, 4'd15, 1'b1, 5'h1F);
    op_check("r032d", 4'd8, 4'd7, 1'b1, 5'h00);

    // start while busy must be ignored
    @(negedge clk);
    a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap = 5'h0A;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        if (ndone == 0) cap = d;
        ndone++;
      end
      @(negedge clk);
    end
    chk("r033_d", cap, 5'h05);
    chk("r033_ndone", ndone, 1);
    chk("r033_idle", busy, 0);

    // start held high, new operands at each done
    @(negedge clk);
    a = sa[0]; b = sb[0]; bin = sc[0]; start = 1'b1;
    i = 0; cyc = 0; last = 0; viol = 0;
    while (i < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy == done) viol++;
      if (done) begin
        chk($sformatf("r034_d%0d", i), d, se[i]);
        if (i > 0)
          chk($sformatf("r034_gap%0d", i),
              cyc - last, 5);
        last = cyc;
        i++;
        if (i < 4) begin
          a = sa[i]; b = sb[i]; bin = sc[i];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("r034_count", i, 4);
    chk("r034_excl", viol, 0);
    chk("r034_first", last - 15, 5);

    // short async reset pulse mid-operation
    @(negedge clk);
    a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("r035_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("r035_busy", busy, 0);
    chk("r035_done", done, 0);
    chk("r035_d", d, 0);
    #2 rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("r035_no_done", ndone, 0);
    chk("r035_no_busy", nbusy, 0);
    op_check("r035_next", 4'd3, 4'd5, 1'b0, 5'h1E);

    // all 512 operand combinations
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++) begin
          logic [4:0] e;
          e = 5'(x - y - z);
          op_check($sformatf("sw_%0d_%0d_%0d", x, y, z),
                   4'(x), 4'(y), 1'(z), e);
        end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_serial.md
SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin one subtraction, sampled on the rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, unsigned.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, unsigned.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a new result is valid.
REQ-010 SHALL have port d, output, WIDTH+1 bits: d[WIDTH-1:0] is the difference; d[WIDTH] is borrow-out.

Function
REQ-011 SHALL compute d = a - b - bin modulo 2^(WIDTH+1), so that d[WIDTH] = 1 exactly when a < b + bin.
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL capture a, b and bin into internal registers, clear the bit counter and the running borrow to bin, and enter SHIFT.
REQ-014 In IDLE, start=0 SHALL keep the FSM in IDLE; in DONE, start=0 SHALL return the FSM to IDLE.
REQ-015 In SHIFT, each edge SHALL process one bit k, where k is the counter value from 0 to WIDTH-1, LSB first.
REQ-016 Bit k SHALL produce diff_k = a_k ^ b_k ^ br.
REQ-017 Bit k SHALL produce the next borrow br' = (~a_k & b_k) | (~(a_k ^ b_k) & br).
REQ-018 The edge that processes bit WIDTH-1 SHALL load d with all WIDTH difference bits plus the final borrow as d[WIDTH], and SHALL enter DONE.
REQ-019 Latency SHALL be exactly WIDTH edges from the start-sampling edge to the edge that loads d; done is high for exactly the following cycle.
REQ-020 busy SHALL be high exactly while the FSM is in SHIFT.
REQ-021 done SHALL be high exactly while the FSM is in DONE.
REQ-022 d SHALL change only at the SHIFT-to-DONE edge and SHALL hold its previous value during SHIFT, DONE and IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 Changes on a, b or bin while busy=1 SHALL NOT affect the operation in progress.
REQ-025 start in DONE SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-026 busy and done SHALL never be high in the same cycle.
REQ-027 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, busy=0, done=0, d=0, bit counter=0 and borrow=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation, with no done pulse and d=0.
REQ-030 After rst_n deasserts, the first rising edge SHALL sample start normally.

Verification (WIDTH=4)
REQ-031 a=9, b=4, bin=0, start for 1 cycle -> busy high 4 cycles, then done 1 cycle with d=5'b0_0101.
REQ-032 a=3, b=5, bin=0 -> d=5'b1_1110; a=0, b=0, bin=1 -> d=5'b1_1111; a=15, b=15, bin=1 -> d=5'b1_1111; a=8, b=7, bin=1 -> d=5'b0_0000.
REQ-033 Operation a=9, b=4 running; at the second busy cycle drive start=1 with a=1, b=2 -> ignored, result 5'b0_0101, no second done.
REQ-034 start held high continuously with new operands applied at each done -> successive results spaced 5 cycles apart, each correct, busy low only during the done cycles.
REQ-035 rst_n pulsed low for less than one clock period during the third busy cycle -> busy=0, done=0 and d=0 immediately; no done follows; the next start gives a correct result.
REQ-036 Random sweep of all 512 (a, b, bin) combinations -> every d matches the reference model a - b - bin mod 32, and latency is 4 in every case.
